// File: rtl/serial_adder_seq.sv
// Bit-serial unsigned adder sequencer: streams operand bit pairs LSB-first into an
// external one-bit full adder and assembles the parallel sum and carry-out.
module serial_adder_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_ci,
    input  logic             fa_s,
    input  logic             fa_co
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] sh_a_r;
    logic [WIDTH-1:0] sh_b_r;
    logic [WIDTH-1:0] sh_s_r;
    logic             carry_r;
    logic [CW-1:0]    cnt_r;

    // Full-adder drive is a pure function of registered state; quiet outside RUN.
    assign fa_a  = (state_r == RUN) ? sh_a_r[0] : 1'b0;
    assign fa_b  = (state_r == RUN) ? sh_b_r[0] : 1'b0;
    assign fa_ci = (state_r == RUN) ? carry_r   : 1'b0;

    // Sequencer FSM, operand/sum shift registers and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            sh_a_r  <= {WIDTH{1'b0}};
            sh_b_r  <= {WIDTH{1'b0}};
            sh_s_r  <= {WIDTH{1'b0}};
            carry_r <= 1'b0;
            cnt_r   <= {CW{1'b0}};
            sum     <= {WIDTH{1'b0}};
            cout    <= 1'b0;
            done    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        sh_a_r  <= a;
                        sh_b_r  <= b;
                        carry_r <= cin;
                        cnt_r   <= {CW{1'b0}};
                        busy    <= 1'b1;
                        state_r <= RUN;
                    end else begin
                        busy    <= 1'b0;
                    end
                end
                RUN: begin
                    sh_a_r  <= {1'b0, sh_a_r[WIDTH-1:1]};
                    sh_b_r  <= {1'b0, sh_b_r[WIDTH-1:1]};
                    sh_s_r  <= {fa_s, sh_s_r[WIDTH-1:1]};
                    carry_r <= fa_co;
                    cnt_r   <= cnt_r + CW'(1);
                    if (cnt_r == CNT_LAST) begin
                        sum     <= {fa_s, sh_s_r[WIDTH-1:1]};
                        cout    <= fa_co;
                        done    <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        done    <= 1'b0;
                    end
                end
                DONE: begin
                    // The edge leaving DONE is the first idle edge, so a held start
                    // reloads here and back-to-back operations run every WIDTH+1 cycles.
                    done <= 1'b0;
                    if (start) begin
                        sh_a_r  <= a;
                        sh_b_r  <= b;
                        carry_r <= cin;
                        cnt_r   <= {CW{1'b0}};
                        busy    <= 1'b1;
                        state_r <= RUN;
                    end else begin
                        busy    <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_seq.sv
// Self-checking bench for serial_adder_seq: WIDTH=8 and WIDTH=4 instances, each
// wired to a behavioural one-bit full adder, compared against plain a+b+cin.
module tb_serial_adder_seq;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        sel   = 1'b0;
    logic [31:0] a_d   = 32'd0;
    logic [31:0] b_d   = 32'd0;
    logic        cin_d = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    logic       busy8, done8, cout8, fa_a8, fa_b8, fa_ci8, fa_s8, fa_co8;
    logic [7:0] sum8;
    logic       busy4, done4, cout4, fa_a4, fa_b4, fa_ci4, fa_s4, fa_co4;
    logic [3:0] sum4;

    logic        o_busy, o_done, o_fa_ci;
    logic [32:0] o_res;

    always #5 clk = ~clk;

    assign fa_s8  = fa_a8 ^ fa_b8 ^ fa_ci8;
    assign fa_co8 = (fa_a8 & fa_b8) | (fa_a8 & fa_ci8) | (fa_b8 & fa_ci8);
    assign fa_s4  = fa_a4 ^ fa_b4 ^ fa_ci4;
    assign fa_co4 = (fa_a4 & fa_b4) | (fa_a4 & fa_ci4) | (fa_b4 & fa_ci4);

    assign o_busy  = sel ? busy4  : busy8;
    assign o_done  = sel ? done4  : done8;
    assign o_fa_ci = sel ? fa_ci4 : fa_ci8;
    assign o_res   = sel ? {28'd0, cout4, sum4} : {24'd0, cout8, sum8};

    serial_adder_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start & ~sel),
        .a(a_d[7:0]), .b(b_d[7:0]), .cin(cin_d),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8),
        .fa_a(fa_a8), .fa_b(fa_b8), .fa_ci(fa_ci8), .fa_s(fa_s8), .fa_co(fa_co8)
    );

    serial_adder_seq #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start & sel),
        .a(a_d[3:0]), .b(b_d[3:0]), .cin(cin_d),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4),
        .fa_a(fa_a4), .fa_b(fa_b4), .fa_ci(fa_ci4), .fa_s(fa_s4), .fa_co(fa_co4)
    );

    function automatic logic [32:0] ref_add(input logic [31:0] av, input logic [31:0] bv,
                                            input logic cv, input int w);
        logic [32:0] mask;
        mask = (33'd1 << w) - 33'd1;
        return ({1'b0, av} & mask) + ({1'b0, bv} & mask) + {32'd0, cv};
    endfunction

    task automatic run_op(input logic [31:0] av, input logic [31:0] bv, input logic cv,
                          output logic [32:0] res, output int lat, output int ci_cnt);
        a_d = av; b_d = bv; cin_d = cv; start = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        lat    = 0;
        ci_cnt = 0;
        while (!o_done && lat < 40) begin
            if (o_busy && o_fa_ci) ci_cnt++;
            @(posedge clk); #1;
            lat++;
        end
        res = o_res;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #2;
        n_checks++;
        if ({busy8, done8, cout8, sum8, fa_a8, fa_b8, fa_ci8} !== 14'd0) begin
            n_fail++;
            $display("FAIL reset_w8: got %h expected 0", {busy8, done8, cout8, sum8, fa_a8, fa_b8, fa_ci8});
        end
        n_checks++;
        if ({busy4, done4, cout4, sum4, fa_a4, fa_b4, fa_ci4} !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_w4: got %h expected 0", {busy4, done4, cout4, sum4, fa_a4, fa_b4, fa_ci4});
        end
        #10 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic;
        logic [7:0] ta [3];
        logic [7:0] tb [3];
        logic       tc [3];
        logic [8:0] te [3];
        logic [32:0] res;
        int lat, ci_cnt;
        ta = '{8'h5A, 8'hFF, 8'hFF};
        tb = '{8'h3C, 8'h01, 8'hFF};
        tc = '{1'b0, 1'b0, 1'b1};
        te = '{9'h096, 9'h100, 9'h1FF};
        sel = 1'b0;
        for (int i = 0; i < 3; i++) begin
            run_op({24'd0, ta[i]}, {24'd0, tb[i]}, tc[i], res, lat, ci_cnt);
            n_checks++;
            if (res !== {24'd0, te[i]}) begin
                n_fail++;
                $display("FAIL basic_result[%0d]: got %h expected %h", i, res, te[i]);
            end
            n_checks++;
            if (lat != 8) begin
                n_fail++;
                $display("FAIL basic_latency[%0d]: got %0d expected 8", i, lat);
            end
            if (i == 2) begin
                n_checks++;
                if (ci_cnt != 8) begin
                    n_fail++;
                    $display("FAIL basic_fa_ci_high: got %0d cycles expected 8", ci_cnt);
                end
            end
            @(posedge clk); #1;
            n_checks++;
            if ({busy8, done8} !== 2'b00) begin
                n_fail++;
                $display("FAIL basic_done_pulse[%0d]: busy,done got %b expected 00", i, {busy8, done8});
            end
        end
    endtask

    task automatic test_ignore_start;
        int n;
        sel = 1'b0;
        a_d = 32'h12; b_d = 32'h34; cin_d = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        repeat (2) begin @(posedge clk); #1; n++; end
        n_checks++;
        if ({cout8, sum8} !== 9'h1FF) begin
            n_fail++;
            $display("FAIL hold_prev_sum: got %h expected 1ff", {cout8, sum8});
        end
        start = 1'b1; a_d = 32'd0; b_d = 32'd0; cin_d = 1'b0;
        @(posedge clk); #1;
        n++;
        start = 1'b0;
        while (!done8 && n < 40) begin @(posedge clk); #1; n++; end
        n_checks++;
        if (n != 8) begin
            n_fail++;
            $display("FAIL ignore_latency: got %0d expected 8", n);
        end
        n_checks++;
        if ({cout8, sum8} !== 9'h047) begin
            n_fail++;
            $display("FAIL ignore_result: got %h expected 047", {cout8, sum8});
        end
        @(posedge clk); #1;
        n_checks++;
        if (busy8 !== 1'b0) begin
            n_fail++;
            $display("FAIL ignore_no_restart: busy got %b expected 0", busy8);
        end
    endtask

    task automatic test_reset_mid_run;
        logic [32:0] res;
        int lat, ci_cnt, seen;
        sel = 1'b0;
        a_d = 32'hAA; b_d = 32'h55; cin_d = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy8, done8, cout8, sum8} !== 11'd0) begin
            n_fail++;
            $display("FAIL midrun_reset: got %h expected 0", {busy8, done8, cout8, sum8});
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done8 || busy8) seen++;
        end
        n_checks++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL midrun_no_done: got %0d active cycles expected 0", seen);
        end
        run_op(32'd3, 32'd4, 1'b0, res, lat, ci_cnt);
        n_checks++;
        if (res !== 33'd7 || lat != 8) begin
            n_fail++;
            $display("FAIL midrun_recover: got %h lat %0d expected 7 lat 8", res, lat);
        end
    endtask

    task automatic test_random_gapped(input int nops);
        logic [32:0] res, exp_v;
        logic [31:0] ra, rb;
        logic        rc;
        int lat, ci_cnt, w;
        for (int i = 0; i < nops; i++) begin
            sel = 1'($urandom_range(0, 1));
            w   = sel ? 4 : 8;
            ra  = $urandom; rb = $urandom; rc = 1'($urandom_range(0, 1));
            exp_v = ref_add(ra, rb, rc, w);
            run_op(ra, rb, rc, res, lat, ci_cnt);
            n_checks++;
            if (res !== exp_v || lat != w) begin
                n_fail++;
                $display("FAIL random_op[%0d] w%0d: got %h lat %0d expected %h lat %0d", i, w, res, lat, exp_v, w);
            end
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        end
    endtask

    task automatic test_start_held(input logic s, input int nops);
        logic [32:0] cur, nxt;
        logic [31:0] ra, rb;
        logic        rc;
        int w, n;
        sel = s;
        w   = s ? 4 : 8;
        ra  = $urandom; rb = $urandom; rc = 1'($urandom_range(0, 1));
        a_d = ra; b_d = rb; cin_d = rc; start = 1'b1;
        cur = ref_add(ra, rb, rc, w);
        nxt = 33'd0;
        @(posedge clk); #1;
        for (int i = 0; i < nops; i++) begin
            if (i < nops - 1) begin
                ra  = $urandom; rb = $urandom; rc = 1'($urandom_range(0, 1));
                a_d = ra; b_d = rb; cin_d = rc;
                nxt = ref_add(ra, rb, rc, w);
            end else begin
                start = 1'b0;
            end
            n = 0;
            while (!o_done && n < 40) begin @(posedge clk); #1; n++; end
            n_checks++;
            if (o_res !== cur || n != w) begin
                n_fail++;
                $display("FAIL held_op[%0d] w%0d: got %h after %0d expected %h after %0d", i, w, o_res, n, cur, w);
            end
            @(posedge clk); #1;
            n_checks++;
            if (o_busy !== (i < nops - 1)) begin
                n_fail++;
                $display("FAIL held_restart[%0d] w%0d: busy got %b expected %b", i, w, o_busy, (i < nops - 1));
            end
            cur = nxt;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ignore_start();
        test_reset_mid_run();
        test_random_gapped(300);
        test_start_held(1'b0, 350);
        test_start_held(1'b1, 350);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
